// File: rtl/operand_stage.sv
// operand_stage: register-file read / operand capture stage that sits in
// front of the ALU. It holds one instruction in a two-state EMPTY/FULL
// skid-less pipeline register with valid/ready handshakes on both sides.
// It also owns the NREG x W register file that the writeback port updates.
//
// Optional feature: define OPERAND_STAGE_BYPASS_EN to forward a same-cycle
// writeback into the operands being captured. Without the macro, the captured
// operand is the register value from before the write.

module operand_stage #(
    parameter int NREG = 8,
    parameter int W    = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    // upstream instruction interface
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [2:0]   IN_OP,
    input  logic [2:0]   IN_RA,
    input  logic [2:0]   IN_RB,
    input  logic [2:0]   IN_RD,
    input  logic [W-1:0] IN_IMM,
    input  logic         IN_USE_IMM,
    // writeback port into the register file
    input  logic         WB_EN,
    input  logic [2:0]   WB_ADDR,
    input  logic [W-1:0] WB_DATA,
    // downstream ALU interface
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] INPUTA,
    output logic [W-1:0] INPUTB,
    output logic [2:0]   OP,
    output logic [2:0]   OUT_RD,
    output logic [7:0]   ISSUE_CNT
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       state_q, state_d;

    logic [W-1:0] inputa_q, inputa_d;
    logic [W-1:0] inputb_q, inputb_d;
    logic [2:0]   op_q, op_d;
    logic [2:0]   out_rd_q, out_rd_d;
    logic [7:0]   issue_cnt_q, issue_cnt_d;

    logic [W-1:0] rf_q [NREG];
    logic [W-1:0] rf_d [NREG];

    logic         full;
    logic         accept;
    logic         issue;
    logic [W-1:0] opa_val;
    logic [W-1:0] opb_reg_val;
    logic [W-1:0] opb_val;

    // Handshake qualifiers. The stage can take a new instruction when it is
    // empty or when its current one is leaving this cycle.
    assign full     = (state_q == ST_FULL);
    assign IN_READY = !full || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign issue    = full && OUT_READY;

    // Register file: each entry is a separate reset-able register because
    // reset has to clear every entry at once.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            assign rf_d[gi] = (WB_EN && (WB_ADDR == 3'(gi))) ? WB_DATA : rf_q[gi];

            // Register file entry storage with asynchronous clear
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    rf_q[gi] <= '0;
                end else begin
                    rf_q[gi] <= rf_d[gi];
                end
            end
        end
    endgenerate

    // Operand selection, including the optional writeback forwarding path
    always_comb begin
        opa_val     = rf_q[IN_RA];
        opb_reg_val = rf_q[IN_RB];
`ifdef OPERAND_STAGE_BYPASS_EN
        if (WB_EN && (WB_ADDR == IN_RA)) begin
            opa_val = WB_DATA;
        end
        if (WB_EN && (WB_ADDR == IN_RB)) begin
            opb_reg_val = WB_DATA;
        end
`endif
        opb_val = IN_USE_IMM ? IN_IMM : opb_reg_val;
    end

    // Next-state logic for the EMPTY/FULL occupancy FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // A same-cycle accept refills the slot as the old one leaves.
                if (issue && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Payload capture: load on accept, otherwise hold so a stalled output
    // stays stable even while writeback changes the source registers
    always_comb begin
        inputa_d = inputa_q;
        inputb_d = inputb_q;
        op_d     = op_q;
        out_rd_d = out_rd_q;
        if (accept) begin
            inputa_d = opa_val;
            inputb_d = opb_val;
            op_d     = IN_OP;
            out_rd_d = IN_RD;
        end
    end

    // Issue counter, free-running modulo 256
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (issue) begin
            issue_cnt_d = issue_cnt_q + 8'd1;
        end
    end

    // State, payload and counter registers with asynchronous clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_EMPTY;
            inputa_q    <= '0;
            inputb_q    <= '0;
            op_q        <= '0;
            out_rd_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inputa_q    <= inputa_d;
            inputb_q    <= inputb_d;
            op_q        <= op_d;
            out_rd_q    <= out_rd_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign OUT_VALID = full;
    assign INPUTA    = inputa_q;
    assign INPUTB    = inputb_q;
    assign OP        = op_q;
    assign OUT_RD    = out_rd_q;
    assign ISSUE_CNT = issue_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed stimulus for operand_stage, with a behavioural
// reference model checked every cycle plus literal expectations for the
// headline scenarios (register read, immediate, stall hold, counter wrap,
// same-cycle writeback, asynchronous reset).

module tb_operand_stage;

    localparam int W = 8;
    localparam logic [2:0] K_ADD = 3'd0;
    localparam logic [2:0] K_XOR = 3'd1;
    localparam logic [2:0] K_SHL = 3'd2;
    localparam logic [2:0] K_SHR = 3'd3;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [2:0]   IN_OP = '0;
    logic [2:0]   IN_RA = '0;
    logic [2:0]   IN_RB = '0;
    logic [2:0]   IN_RD = '0;
    logic [W-1:0] IN_IMM = '0;
    logic         IN_USE_IMM = 1'b0;
    logic         WB_EN = 1'b0;
    logic [2:0]   WB_ADDR = '0;
    logic [W-1:0] WB_DATA = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] INPUTA;
    logic [W-1:0] INPUTB;
    logic [2:0]   OP;
    logic [2:0]   OUT_RD;
    logic [7:0]   ISSUE_CNT;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [W-1:0] m_rf [8];
    bit           m_valid = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [2:0]   m_op = '0;
    logic [2:0]   m_rd = '0;
    logic [7:0]   m_cnt = '0;

    operand_stage #(.NREG(8), .W(W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_OP      (IN_OP),
        .IN_RA      (IN_RA),
        .IN_RB      (IN_RB),
        .IN_RD      (IN_RD),
        .IN_IMM     (IN_IMM),
        .IN_USE_IMM (IN_USE_IMM),
        .WB_EN      (WB_EN),
        .WB_ADDR    (WB_ADDR),
        .WB_DATA    (WB_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .INPUTA     (INPUTA),
        .INPUTB     (INPUTB),
        .OP         (OP),
        .OUT_RD     (OUT_RD),
        .ISSUE_CNT  (ISSUE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_valid = 1'b0;
        m_a = '0;
        m_b = '0;
        m_op = '0;
        m_rd = '0;
        m_cnt = '0;
    endtask

    // Model: a one-entry slot in front of an 8-entry register array.
    initial begin
        logic         rdy;
        logic         acc;
        logic         iss;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        model_clear();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                model_clear();
            end else begin
                rdy = !m_valid || OUT_READY;
                acc = IN_VALID && rdy;
                iss = m_valid && OUT_READY;
                va = m_rf[IN_RA];
                vb = m_rf[IN_RB];
`ifdef OPERAND_STAGE_BYPASS_EN
                if (WB_EN && WB_ADDR == IN_RA) va = WB_DATA;
                if (WB_EN && WB_ADDR == IN_RB) vb = WB_DATA;
`endif
                if (iss) m_cnt = m_cnt + 8'd1;
                if (acc) begin
                    m_valid = 1'b1;
                    m_a = va;
                    m_b = IN_USE_IMM ? IN_IMM : vb;
                    m_op = IN_OP;
                    m_rd = IN_RD;
                end else if (iss) begin
                    m_valid = 1'b0;
                end
                if (WB_EN) m_rf[WB_ADDR] = WB_DATA;
            end
        end
    end

    // Per-cycle compare against the model, away from the rising edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check("out_valid", 32'(OUT_VALID), 32'(m_valid));
            check("in_ready", 32'(IN_READY), 32'(!m_valid || OUT_READY));
            check("issue_cnt", 32'(ISSUE_CNT), 32'(m_cnt));
            if (m_valid) begin
                check("inputa", 32'(INPUTA), 32'(m_a));
                check("inputb", 32'(INPUTB), 32'(m_b));
                check("op", 32'(OP), 32'(m_op));
                check("out_rd", 32'(OUT_RD), 32'(m_rd));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [W-1:0] data);
        WB_EN = 1'b1;
        WB_ADDR = addr;
        WB_DATA = data;
        step();
        WB_EN = 1'b0;
    endtask

    task automatic offer(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic use_imm, input logic [W-1:0] imm);
        IN_VALID = 1'b1;
        IN_OP = op;
        IN_RA = ra;
        IN_RB = rb;
        IN_RD = rd;
        IN_USE_IMM = use_imm;
        IN_IMM = imm;
    endtask

    initial begin
        bit wrap_seen;
        logic [W-1:0] exp_fwd;

        // reset state
        step();
        step();
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_issue_cnt", 32'(ISSUE_CNT), 32'd0);
        check("rst_inputa", 32'(INPUTA), 32'd0);
        RESET = 1'b0;
        chk_en = 1'b1;

        // register read into operands
        wb(3'd1, 8'hAA);
        wb(3'd2, 8'h03);
        OUT_READY = 1'b0;
        offer(K_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00);
        step();
        IN_VALID = 1'b0;
        check("add_valid", 32'(OUT_VALID), 32'd1);
        check("add_a", 32'(INPUTA), 32'hAA);
        check("add_b", 32'(INPUTB), 32'h03);
        check("add_op", 32'(OP), 32'(K_ADD));
        check("add_rd", 32'(OUT_RD), 32'd3);
        $display("txn add: A=%0h B=%0h op=%0d rd=%0d", INPUTA, INPUTB, OP, OUT_RD);

        // issue plus same-cycle accept of an immediate instruction
        OUT_READY = 1'b1;
        offer(K_SHL, 3'd1, 3'd0, 3'd4, 1'b1, 8'h02);
        step();
        check("shl_a", 32'(INPUTA), 32'hAA);
        check("shl_b", 32'(INPUTB), 32'h02);
        check("shl_op", 32'(OP), 32'(K_SHL));
        check("shl_cnt", 32'(ISSUE_CNT), 32'd1);
        $display("txn shl: A=%0h B=%0h cnt=%0d", INPUTA, INPUTB, ISSUE_CNT);

        // stall for 3 cycles while writeback overwrites the source register
        OUT_READY = 1'b0;
        offer(K_SHR, 3'd1, 3'd1, 3'd5, 1'b0, 8'h00);
        WB_EN = 1'b1;
        WB_ADDR = 3'd1;
        WB_DATA = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_a", 32'(INPUTA), 32'hAA);
            check("hold_b", 32'(INPUTB), 32'h02);
            check("hold_in_ready", 32'(IN_READY), 32'd0);
            $display("txn hold %0d: A=%0h B=%0h in_ready=%0d", i, INPUTA, INPUTB, IN_READY);
        end
        WB_EN = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        step();
        check("drain_valid", 32'(OUT_VALID), 32'd0);
        check("drain_cnt", 32'(ISSUE_CNT), 32'd2);

        // back-to-back throughput and counter wrap
        wrap_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            offer(3'(i % 6), 3'(i % 8), 3'((i + 3) % 8), 3'(i % 8), 1'(i % 2), 8'(i));
            step();
            if (ISSUE_CNT == 8'd0) wrap_seen = 1'b1;
        end
        IN_VALID = 1'b0;
        step();
        check("b2b_cnt_after", 32'(ISSUE_CNT), 32'd2);
        check("b2b_wrap_seen", 32'(wrap_seen), 32'd1);
        $display("txn b2b: 256 issues, cnt=%0d wrap_seen=%0d", ISSUE_CNT, wrap_seen);

        // same-cycle writeback and accept of the same register
        wb(3'd1, 8'hAA);
        WB_EN = 1'b1;
        WB_ADDR = 3'd1;
        WB_DATA = 8'h0F;
        offer(K_XOR, 3'd1, 3'd2, 3'd6, 1'b0, 8'h00);
        step();
        WB_EN = 1'b0;
`ifdef OPERAND_STAGE_BYPASS_EN
        exp_fwd = 8'h0F;
`else
        exp_fwd = 8'hAA;
`endif
        check("wb_same_cycle_a", 32'(INPUTA), 32'(exp_fwd));
        $display("txn wb_fwd: A=%0h", INPUTA);
        offer(K_ADD, 3'd1, 3'd2, 3'd7, 1'b0, 8'h00);
        step();
        IN_VALID = 1'b0;
        check("wb_reread_a", 32'(INPUTA), 32'h0F);
        $display("txn reread: A=%0h", INPUTA);

        // asynchronous reset mid-cycle while full and stalled
        OUT_READY = 1'b0;
        offer(K_XOR, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);
        step();
        IN_VALID = 1'b0;
        check("pre_rst_valid", 32'(OUT_VALID), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        check("arst_valid", 32'(OUT_VALID), 32'd0);
        check("arst_cnt", 32'(ISSUE_CNT), 32'd0);
        check("arst_in_ready", 32'(IN_READY), 32'd1);
        check("arst_a", 32'(INPUTA), 32'd0);
        // writes and accepts must be ignored while reset is held
        WB_EN = 1'b1;
        WB_ADDR = 3'd2;
        WB_DATA = 8'h77;
        offer(K_ADD, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00);
        step();
        check("rst_hold_valid", 32'(OUT_VALID), 32'd0);
        WB_EN = 1'b0;
        IN_VALID = 1'b0;
        RESET = 1'b0;
        step();
        OUT_READY = 1'b1;
        for (int r = 0; r < 8; r++) begin
            offer(K_ADD, 3'(r), 3'(r), 3'(r), 1'b0, 8'h00);
            step();
            check("post_rst_a", 32'(INPUTA), 32'd0);
            check("post_rst_b", 32'(INPUTB), 32'd0);
            $display("txn post-reset read R%0d: A=%0h B=%0h", r, INPUTA, INPUTB);
        end
        IN_VALID = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
